imem_bit_streamer: RTL and testbench

Parametrised successor to the instruction-memory fetch controller. It reads a byte-counted packet from the read-only instruction memory starting at a programmable word address. It presents the data to the BITS decoder FSM as an MSB-first sliding bit window, and the FSM consumes a variable number of bits per cycle. It keeps fetching in the background while buffer space allows, so decoding never has to wait for a fixed 128-bit block.

---
 rtl/imem_bit_streamer_pkg.sv | 17 +
 rtl/imem_bit_streamer_if.sv | 17 +
 rtl/imem_bit_streamer_bit_shift_buffer.sv | 74 +++++++
 rtl/imem_bit_streamer.sv | 185 ++++++++++++++++++
 tb/tb_imem_bit_streamer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_bit_streamer_pkg.sv
// Shared definitions for the instruction-memory bit streamer.
//   state_e        : controller FSM state encoding
//   bytes_to_bits  : byte count -> bit count helper
package imem_bit_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int unsigned bytes_to_bits(input int unsigned nbytes);
        return nbytes * 8;
    endfunction

endpackage

// File: rtl/imem_bit_streamer_if.sv
// Instruction-memory read bus.
//   ceb   : chip enable, active-low     (master -> slave)
//   web   : write enable, active-low    (master -> slave)
//   addr  : word address                (master -> slave)
//   rdata : read data, one cycle after the memory samples ceb=0 (slave -> master)
interface imem_bit_streamer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              ceb;
    logic              web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    modport master (output ceb, output web, output addr, input rdata);
    modport slave  (input ceb, input web, input addr, output rdata);
endinterface

// File: rtl/imem_bit_streamer_bit_shift_buffer.sv
// Left-aligned bit buffer with variable left-shift (pop) and append (capture).
//   clk, resetB : clock, async active-low reset
//   clr         : drop all contents (wins over pop and capture)
//   pop_en      : shift out pop_cnt bits (caller guarantees pop_cnt <= fill)
//   pop_cnt     : number of bits to shift out
//   cap_en      : append the top cap_bits of cap_data after the remaining bits
//   cap_data    : captured memory word, first byte in the MSBs
//   cap_bits    : valid bits of cap_data (DATA_W, or less for the last word)
//   win_o       : oldest WIN_W bits, MSB oldest
//   fill_o      : number of valid bits held
module imem_bit_streamer_bit_shift_buffer #(
    parameter int DATA_W = 32,
    parameter int WIN_W  = 64,
    parameter int BUF_W  = 128,
    parameter int POP_W  = $clog2(WIN_W) + 1,
    parameter int FILL_W = $clog2(BUF_W + 1),
    parameter int LB_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              clr,
    input  logic              pop_en,
    input  logic [POP_W-1:0]  pop_cnt,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [LB_W-1:0]   cap_bits,
    output logic [WIN_W-1:0]  win_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [BUF_W-1:0]  buf_q, buf_d, shifted, placed;
    logic [FILL_W-1:0] fill_q, fill_d, fill_s;
    logic [DATA_W-1:0] cap_mask;

    // Trailing bytes of a partial last word are zeroed so that every bit
    // beyond fill stays 0 and the window never shows stale data.
    assign cap_mask = ~({DATA_W{1'b1}} >> cap_bits);

    always_comb begin
        shifted = buf_q;
        fill_s  = fill_q;
        if (pop_en) begin
            shifted = buf_q << pop_cnt;
            fill_s  = fill_q - FILL_W'(pop_cnt);
        end
        // The new word lands directly after the post-pop contents, so a pop
        // and a capture in the same cycle compose correctly.
        placed = {cap_data & cap_mask, {(BUF_W-DATA_W){1'b0}}} >> fill_s;
        buf_d  = shifted;
        fill_d = fill_s;
        if (cap_en) begin
            buf_d  = shifted | placed;
            fill_d = fill_s + FILL_W'(cap_bits);
        end
        if (clr) begin
            buf_d  = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign win_o  = buf_q[BUF_W-1 -: WIN_W];
    assign fill_o = fill_q;

endmodule

// File: rtl/imem_bit_streamer.sv
// Streams a byte-counted packet out of read-only instruction memory as an
// MSB-first sliding bit window; the consumer pops a variable bit count per cycle.
//   clk, resetB          : clock, async active-low reset
//   mem                  : memory read bus (ceb/web/addr out, rdata in)
//   start                : begin a packet (accepted in IDLE or DONE)
//   abort                : flush and return to IDLE (wins over start)
//   startAddr            : first word address, latched on start
//   expectedBytes        : packet length in bytes, latched on start
//   popEn, popCount      : consume popCount bits at the next edge
//   window               : next unconsumed bits, MSB oldest, zero beyond fill
//   validBits            : min(fill, WIN_W)
//   popError             : sticky, set by an over-long pop
//   done_reading_memory  : every packet word has been captured
//   streamEmpty          : done_reading_memory and buffer empty
module imem_bit_streamer
    import imem_bit_streamer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 64,
    parameter int BUF_W  = 128,
    parameter int POP_W  = $clog2(WIN_W) + 1
) (
    input  logic                clk,
    input  logic                resetB,
    imem_bit_streamer_if.master mem,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   startAddr,
    input  logic [CNT_W-1:0]    expectedBytes,
    input  logic                popEn,
    input  logic [POP_W-1:0]    popCount,
    output logic [WIN_W-1:0]    window,
    output logic [POP_W-1:0]    validBits,
    output logic                popError,
    output logic                done_reading_memory,
    output logic                streamEmpty
);

    localparam int BPW    = DATA_W / 8;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int LB_W   = $clog2(DATA_W + 1);
    localparam int RD_LAT = 2;

    state_e            state_q, state_d;
    logic              ceb_q;
    logic [ADDR_W-1:0] addr_q;
    // vld_pipe[1]: read issued, memory samples at the coming edge
    // vld_pipe[2]: read data on imem_rdata, captured at the coming edge
    logic [RD_LAT:1]   vld_pipe;
    logic [CNT_W-1:0]  issue_left_q, capt_left_q;
    logic [LB_W-1:0]   last_bits_q;
    logic              pop_err_q, done_q;
    logic [FILL_W-1:0] fill;

    logic              start_ok, flush, issue, capture, last_cap;
    logic              room_ok, pop_over, pop_ok;
    logic [1:0]        pending;
    logic [CNT_W-1:0]  start_words, start_rem;
    logic [LB_W-1:0]   start_last_bits, cap_bits;
    logic [31:0]       need_bits;

    assign start_ok = start & ~abort & (state_q == ST_IDLE || state_q == ST_DONE);
    assign flush    = abort | start_ok;

    assign start_words     = CNT_W'((32'(expectedBytes) + 32'(BPW - 1)) / 32'(BPW));
    assign start_rem       = CNT_W'(32'(expectedBytes) % 32'(BPW));
    assign start_last_bits = (start_rem == '0) ? LB_W'(DATA_W)
                                               : LB_W'(bytes_to_bits(32'(start_rem)));

    // Reserve buffer space for every read already in flight plus this one.
    assign pending   = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};
    assign need_bits = 32'(fill) + (32'(pending) + 32'd1) * 32'(DATA_W);
    assign room_ok   = need_bits <= 32'(BUF_W);

    always_comb begin
        issue = 1'b0;
        if (abort)
            issue = 1'b0;
        else if (start_ok)
            issue = (expectedBytes != '0);
        else
            issue = (state_q == ST_FETCH) && (issue_left_q != '0) && room_ok;
    end

    // Words in flight across a flush belong to the old packet and are dropped.
    assign capture  = vld_pipe[RD_LAT] & ~flush;
    assign last_cap = capture & (capt_left_q == CNT_W'(1));
    assign cap_bits = last_cap ? last_bits_q : LB_W'(DATA_W);

    assign pop_over = popEn & (popCount > validBits);
    assign pop_ok   = popEn & ~pop_over & ~flush;

    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = ST_IDLE;
        else if (start_ok)
            state_d = (expectedBytes == '0) ? ST_DONE : ST_FETCH;
        else begin
            case (state_q)
                ST_FETCH: if (last_cap)     state_d = ST_DRAIN;
                ST_DRAIN: if (fill == '0)   state_d = ST_DONE;
                default:                    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q      <= ST_IDLE;
            ceb_q        <= 1'b1;
            addr_q       <= '0;
            vld_pipe     <= '0;
            issue_left_q <= '0;
            capt_left_q  <= '0;
            last_bits_q  <= '0;
            pop_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            ceb_q    <= ~issue;
            vld_pipe <= {vld_pipe[1] & ~flush, issue};

            if (abort) begin
                issue_left_q <= '0;
                capt_left_q  <= '0;
            end else if (start_ok) begin
                // The first read goes out with the start edge itself.
                addr_q       <= startAddr;
                issue_left_q <= start_words - {{(CNT_W-1){1'b0}}, |expectedBytes};
                capt_left_q  <= start_words;
                last_bits_q  <= start_last_bits;
            end else begin
                if (issue) begin
                    addr_q       <= addr_q + 1'b1;
                    issue_left_q <= issue_left_q - 1'b1;
                end
                if (capture)
                    capt_left_q <= capt_left_q - 1'b1;
            end

            if (flush)
                pop_err_q <= 1'b0;
            else if (pop_over)
                pop_err_q <= 1'b1;

            if (flush)
                done_q <= start_ok & (expectedBytes == '0);
            else if (last_cap)
                done_q <= 1'b1;
        end
    end

    imem_bit_streamer_bit_shift_buffer #(
        .DATA_W (DATA_W),
        .WIN_W  (WIN_W),
        .BUF_W  (BUF_W),
        .POP_W  (POP_W),
        .FILL_W (FILL_W),
        .LB_W   (LB_W)
    ) u_buf (
        .clk      (clk),
        .resetB   (resetB),
        .clr      (flush),
        .pop_en   (pop_ok),
        .pop_cnt  (popCount),
        .cap_en   (capture),
        .cap_data (mem.rdata),
        .cap_bits (cap_bits),
        .win_o    (window),
        .fill_o   (fill)
    );

    assign validBits           = (fill > FILL_W'(WIN_W)) ? POP_W'(WIN_W) : POP_W'(fill);
    assign popError            = pop_err_q;
    assign done_reading_memory = done_q;
    assign streamEmpty         = done_q & (fill == '0);

    assign mem.ceb  = ceb_q;
    assign mem.web  = 1'b1;
    assign mem.addr = addr_q;

endmodule

// File: tb/tb_imem_bit_streamer.sv
module tb_imem_bit_streamer;
    localparam int DATA_W = 32, ADDR_W = 10, CNT_W = 16, WIN_W = 64, BUF_W = 128, POP_W = 7;
    localparam int BPW = DATA_W / 8;

    logic clk = 1'b0;
    logic resetB = 1'b1;
    always #5 clk = ~clk;

    imem_bit_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    logic              start = 1'b0, abort = 1'b0, popEn = 1'b0;
    logic [ADDR_W-1:0] startAddr = '0;
    logic [CNT_W-1:0]  expectedBytes = '0;
    logic [POP_W-1:0]  popCount = '0;
    logic [WIN_W-1:0]  window;
    logic [POP_W-1:0]  validBits;
    logic              popError, done_rd, streamEmpty;

    imem_bit_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .WIN_W(WIN_W), .BUF_W(BUF_W), .POP_W(POP_W)
    ) dut (
        .clk(clk), .resetB(resetB), .mem(mem_if),
        .start(start), .abort(abort), .startAddr(startAddr), .expectedBytes(expectedBytes),
        .popEn(popEn), .popCount(popCount),
        .window(window), .validBits(validBits), .popError(popError),
        .done_reading_memory(done_rd), .streamEmpty(streamEmpty)
    );

    // Synchronous-read memory model.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_if.ceb == 1'b0) mem_if.rdata <= mem[mem_if.addr];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Scoreboard: expected bit stream and read addresses of the current packet.
    bit                exp_bits[$];
    logic [ADDR_W-1:0] exp_addr[$];
    bit                exp_err = 1'b0;
    int                issued = 0, popped = 0;
    bit                mon_en = 1'b0;
    logic [63:0]       expw;
    int                vb;

    always @(negedge clk) if (mon_en) begin
        if (mem_if.ceb == 1'b0) begin
            issued++;
            if (exp_addr.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL spurious_read: addr %h, required no read", mem_if.addr);
            end else
                chk("read_addr", 64'(mem_if.addr), 64'(exp_addr.pop_front()));
            chk("web", 64'(mem_if.web), 64'd1);
        end
        vb = int'(validBits);
        chk("validBits_bound", 64'(vb <= exp_bits.size() && vb <= WIN_W), 64'd1);
        expw = '0;
        for (int i = 0; i < vb && i < exp_bits.size(); i++) expw[63-i] = exp_bits[i];
        chk("window", window, expw);
        chk("popError", 64'(popError), 64'(exp_err));
        chk("buffer_budget", 64'(issued * DATA_W - popped <= BUF_W), 64'd1);

        if (abort || start) begin
            exp_bits.delete(); exp_addr.delete();
            exp_err = 1'b0; issued = 0; popped = 0;
        end
        if (start && !abort) begin
            for (int w = 0; w < (int'(expectedBytes) + BPW - 1) / BPW; w++)
                exp_addr.push_back(ADDR_W'(int'(startAddr) + w));
            for (int i = 0; i < int'(expectedBytes); i++) begin
                logic [DATA_W-1:0] wd;
                logic [7:0] by;
                wd = mem[ADDR_W'(int'(startAddr) + i / BPW)];
                by = wd[DATA_W-1-8*(i%BPW) -: 8];
                for (int b = 7; b >= 0; b--) exp_bits.push_back(by[b]);
            end
        end else if (!abort && popEn) begin
            if (int'(popCount) > vb) exp_err = 1'b1;
            else begin
                for (int k = 0; k < int'(popCount) && exp_bits.size() > 0; k++) void'(exp_bits.pop_front());
                popped += int'(popCount);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        tick();
        startAddr = a; expectedBytes = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_pop(input int n);
        popEn = 1'b1; popCount = POP_W'(n);
        tick();
        popEn = 1'b0; popCount = '0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done_rd && c < budget) begin tick(); c++; end
        if (!done_rd) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: done_reading_memory 0 after %0d cycles, required 1", budget);
        end
    endtask

    // mode 0: pop everything visible, 1: pop 3 per cycle, 2: random with occasional over-pop
    task automatic drain(input int mode, input int budget);
        int c = 0;
        int v;
        while (!streamEmpty && c < budget) begin
            v = int'(validBits);
            popEn = 1'b1;
            case (mode)
                0: popCount = POP_W'(v);
                1: popCount = POP_W'((v >= 3) ? 3 : v);
                default: begin
                    if ($urandom_range(0, 19) == 0 && v < WIN_W) popCount = POP_W'(v + 1);
                    else if ($urandom_range(0, 3) == 0) popEn = 1'b0;
                    else popCount = POP_W'($urandom_range(0, v));
                end
            endcase
            tick(); c++;
        end
        popEn = 1'b0; popCount = '0;
        if (!streamEmpty) begin
            n_chk++; n_fail++;
            $display("FAIL drain: streamEmpty 0 after %0d cycles, required 1", budget);
        end else begin
            chk("done_at_empty", 64'(done_rd), 64'd1);
            chk("model_empty", 64'(exp_bits.size()), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        #2 resetB = 1'b0;
        #1;
        chk("rst_ceb", 64'(mem_if.ceb), 64'd1);
        chk("rst_web", 64'(mem_if.web), 64'd1);
        chk("rst_addr", 64'(mem_if.addr), 64'd0);
        chk("rst_window", window, 64'd0);
        chk("rst_validBits", 64'(validBits), 64'd0);
        chk("rst_popError", 64'(popError), 64'd0);
        chk("rst_done", 64'(done_rd), 64'd0);
        chk("rst_streamEmpty", 64'(streamEmpty), 64'd0);
        repeat (2) tick();
        resetB = 1'b1;
        mon_en = 1'b1;

        // Two full words, no pops.
        mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567;
        do_start(10'h000, 16'd8);
        wait_done(50);
        chk("t1_window", window, 64'hDEADBEEF01234567);
        chk("t1_validBits", 64'(validBits), 64'd64);
        chk("t1_done", 64'(done_rd), 64'd1);
        drain(0, 50);

        // Partial last word.
        mem[10'h20] = 32'hAABBCCDD; mem[10'h21] = 32'hEEFF0011;
        do_start(10'h020, 16'd5);
        wait_done(50);
        chk("t2_validBits", 64'(validBits), 64'd40);
        chk("t2_window_hi", 64'(window[63:24]), 64'hAABBCCDDEE);
        chk("t2_window_lo", 64'(window[23:0]), 64'd0);
        do_pop(40);
        chk("t2_streamEmpty", 64'(streamEmpty), 64'd1);

        // Address wrap.
        do_start(10'h3FF, 16'd8);
        wait_done(50);
        drain(0, 50);

        // Long packet with steady pop(3): throttled by buffer space.
        do_start(10'h100, 16'd64);
        drain(1, 1000);
        chk("t4_popError", 64'(popError), 64'd0);

        // Over-long pop is ignored and flagged.
        do_start(10'h200, 16'd2);
        wait_done(50);
        chk("t5_vb16", 64'(validBits), 64'd16);
        do_pop(6);
        chk("t5_vb10", 64'(validBits), 64'd10);
        do_pop(11);
        chk("t5_err", 64'(popError), 64'd1);
        chk("t5_vb_kept", 64'(validBits), 64'd10);
        do_pop(10);
        chk("t5_vb0", 64'(validBits), 64'd0);
        chk("t5_empty", 64'(streamEmpty), 64'd1);

        // Abort with reads in flight, then an empty packet.
        do_start(10'h300, 16'd64);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_vb", 64'(validBits), 64'd0);
        chk("t6_abort_done", 64'(done_rd), 64'd0);
        do_start(10'h000, 16'd0);
        chk("t6_vb", 64'(validBits), 64'd0);
        chk("t6_done", 64'(done_rd), 64'd1);
        chk("t6_empty", 64'(streamEmpty), 64'd1);
        repeat (4) tick();
        chk("t6_empty_hold", 64'(streamEmpty), 64'd1);

        // Randomized packets.
        for (int k = 0; k < 12; k++) begin
            do_start(ADDR_W'($urandom), CNT_W'($urandom_range(1, 80)));
            drain(int'($urandom_range(0, 2)), 3000);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
